// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit : in-order instruction fetch with a 2-entry {pc, insn} buffer, |
// |              wrong-path response dropping and redirect handling.         |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    input  logic        STALL,
    input  logic        CONDITIONAL_JUMP,
    input  logic        MRET,
    input  logic        REDIRECT_VALID,
    input  logic [31:0] REDIRECT_PC,
    output logic        DECODER_ENABLED,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC
);

    typedef enum logic [0:0] {
        S_FETCH         = 1'b0,
        S_WAIT_REDIRECT = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_fifo_pc   [2];
    logic [31:0] r_fifo_insn [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic [1:0]  r_outstanding;
    logic [1:0]  r_drop;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_last_pc;

    logic        w_empty;
    logic        w_req;
    logic        w_grant;
    logic        w_issue;
    logic        w_jump;
    logic        w_flush;
    logic        w_rsp_keep;
    logic        w_rsp_drop;
    logic        w_push;
    logic [1:0]  w_out_next;
    logic [31:0] w_rsp_pc;
    logic [31:0] w_head_pc;
    logic        w_unused_redirect_lsb;

    assign w_unused_redirect_lsb = ^REDIRECT_PC[1:0];

    assign w_empty    = (r_count == 2'd0);
    assign w_req      = !RST && (r_state == S_FETCH) && !REDIRECT_VALID
                        && (({1'b0, r_outstanding} + {1'b0, r_count}) < 3'd2);
    assign w_grant    = w_req && IMEM_GNT;
    assign w_issue    = (r_state == S_FETCH) && !w_empty && !STALL && !REDIRECT_VALID;
    assign w_jump     = w_issue && (CONDITIONAL_JUMP || MRET);
    assign w_flush    = REDIRECT_VALID || w_jump;
    assign w_rsp_keep = IMEM_RVALID && (r_drop == 2'd0);
    assign w_rsp_drop = IMEM_RVALID && (r_drop != 2'd0);
    assign w_push     = w_rsp_keep && !w_flush;
    assign w_out_next = r_outstanding + {1'b0, w_grant} - {1'b0, IMEM_RVALID};

    // Kept responses are always the newest requests, so the oldest live one
    // sits exactly 'outstanding' words behind the next fetch address.
    assign w_rsp_pc   = r_fetch_pc - {28'd0, r_outstanding, 2'b00};
    assign w_head_pc  = r_fifo_pc[r_rd_ptr];

    assign IMEM_REQ        = w_req;
    assign IMEM_ADDR       = r_fetch_pc;
    assign DECODER_ENABLED = w_issue;
    assign INSTRUCTION     = w_empty ? NOP_INSN : r_fifo_insn[r_rd_ptr];
    assign PC              = w_empty ? r_last_pc : w_head_pc;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state        <= S_FETCH;
            r_fifo_pc[0]   <= '0;
            r_fifo_pc[1]   <= '0;
            r_fifo_insn[0] <= '0;
            r_fifo_insn[1] <= '0;
            r_rd_ptr       <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_count        <= 2'd0;
            r_outstanding  <= 2'd0;
            r_drop         <= 2'd0;
            r_fetch_pc     <= RESET_PC;
            r_last_pc      <= RESET_PC;
        end else begin
            r_outstanding <= w_out_next;

            if (REDIRECT_VALID) begin
                r_fetch_pc <= {REDIRECT_PC[31:2], 2'b00};
            end else if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end

            if (w_issue) begin
                r_last_pc <= w_head_pc;
            end

            // Every request still in flight after a flush is wrong-path.
            if (w_flush) begin
                r_count  <= 2'd0;
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
                r_drop   <= w_out_next;
                r_state  <= REDIRECT_VALID ? S_FETCH : S_WAIT_REDIRECT;
            end else begin
                if (w_push) begin
                    r_fifo_pc[r_wr_ptr]   <= w_rsp_pc;
                    r_fifo_insn[r_wr_ptr] <= IMEM_RDATA;
                    r_wr_ptr              <= ~r_wr_ptr;
                end
                if (w_issue) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_issue};
                if (w_rsp_drop) begin
                    r_drop <= r_drop - 2'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_unit : scoreboard bench for fetch_unit with an in-order memory.  |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC_TB = 32'h0000_0000;
    localparam logic [31:0] NOP_TB      = 32'h0000_0013;
    localparam logic [31:0] NO_ADDR     = 32'hFFFF_FFF0;
    localparam logic [31:0] BEQ_WORD    = 32'h0000_0063;
    localparam logic [31:0] JAL_WORD    = 32'h0000_006F;
    localparam logic [31:0] MRET_WORD   = 32'h3020_0073;

    logic        CLK;
    logic        RST;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic        STALL;
    logic        CONDITIONAL_JUMP;
    logic        MRET;
    logic        REDIRECT_VALID;
    logic [31:0] REDIRECT_PC;
    logic        DECODER_ENABLED;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC;

    int          checks;
    int          failures;
    int          n_issued;
    int          n_granted;
    int          cyc;
    int          mem_delay;
    logic        gnt_rand;
    logic        mon_en;
    logic [31:0] br_addr;
    logic [31:0] jal_addr;
    logic [31:0] mret_addr;
    logic [31:0] exp_q [$];
    logic [31:0] mq_addr [$];
    int          mq_due [$];
    logic        acc;
    logic [31:0] acc_addr;

    fetch_unit #(
        .RESET_PC (RESET_PC_TB),
        .NOP_INSN (NOP_TB)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .IMEM_REQ         (IMEM_REQ),
        .IMEM_ADDR        (IMEM_ADDR),
        .IMEM_GNT         (IMEM_GNT),
        .IMEM_RVALID      (IMEM_RVALID),
        .IMEM_RDATA       (IMEM_RDATA),
        .STALL            (STALL),
        .CONDITIONAL_JUMP (CONDITIONAL_JUMP),
        .MRET             (MRET),
        .REDIRECT_VALID   (REDIRECT_VALID),
        .REDIRECT_PC      (REDIRECT_PC),
        .DECODER_ENABLED  (DECODER_ENABLED),
        .INSTRUCTION      (INSTRUCTION),
        .PC               (PC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == br_addr)   return BEQ_WORD;
        if (a == jal_addr)  return JAL_WORD;
        if (a == mret_addr) return MRET_WORD;
        return {a[13:2], 5'd0, 3'b000, 5'd1, 7'h13};
    endfunction

    // Decoder model: combinational from the issued word.
    assign CONDITIONAL_JUMP = (INSTRUCTION[6:0] == 7'h63) || (INSTRUCTION[6:0] == 7'h6F)
                              || (INSTRUCTION[6:0] == 7'h67);
    assign MRET             = (INSTRUCTION == MRET_WORD);

    // Memory: grants sampled mid-cycle, responses in order after mem_delay cycles.
    always @(negedge CLK) begin
        if (RST) begin
            mq_addr.delete();
            mq_due.delete();
            acc = 1'b0;
        end else begin
            acc      = IMEM_REQ && IMEM_GNT;
            acc_addr = IMEM_ADDR;
        end
    end

    always @(posedge CLK) begin
        #1;
        cyc++;
        IMEM_GNT = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (RST) begin
            IMEM_RVALID = 1'b0;
            IMEM_RDATA  = 32'h0;
        end else begin
            if (acc) begin
                mq_addr.push_back(acc_addr);
                mq_due.push_back(cyc + mem_delay - 1);
                n_granted++;
            end
            acc = 1'b0;
            if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
                IMEM_RVALID = 1'b1;
                IMEM_RDATA  = mem_word(mq_addr.pop_front());
                void'(mq_due.pop_front());
            end else begin
                IMEM_RVALID = 1'b0;
                IMEM_RDATA  = 32'h0;
            end
        end
    end

    // Scoreboard: every issue must match the next expected PC and its word.
    always @(negedge CLK) begin
        logic [31:0] e;
        if (mon_en && !RST && DECODER_ENABLED) begin
            checks++;
            n_issued++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_issue pc=%h insn=%h required=none", PC, INSTRUCTION);
            end else begin
                e = exp_q.pop_front();
                if (PC !== e || INSTRUCTION !== mem_word(e)) begin
                    failures++;
                    $display("FAIL issue pc=%h insn=%h required pc=%h insn=%h",
                             PC, INSTRUCTION, e, mem_word(e));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic apply_reset();
        @(posedge CLK);
        #1;
        RST = 1'b1; STALL = 1'b0; REDIRECT_VALID = 1'b0; REDIRECT_PC = 32'h0;
        mon_en = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0; n_issued = 0; n_granted = 0; mon_en = 1'b1;
    endtask

    task automatic push_range(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if (IMEM_REQ !== 1'b0 || DECODER_ENABLED !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes req=%b de=%b required 0 0", IMEM_REQ, DECODER_ENABLED);
        end
        checks++;
        if (INSTRUCTION !== NOP_TB || PC !== RESET_PC_TB) begin
            failures++;
            $display("FAIL reset_outputs insn=%h pc=%h required %h %h", INSTRUCTION, PC, NOP_TB, RESET_PC_TB);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== RESET_PC_TB) begin
            failures++;
            $display("FAIL reset_first_req req=%b addr=%h required 1 %h", IMEM_REQ, IMEM_ADDR, RESET_PC_TB);
        end
    endtask

    task automatic test_straight();
        int first;
        apply_reset();
        push_range(32'h0, 16);
        first = -1;
        for (int c = 0; c < 10 && first < 0; c++) begin
            @(negedge CLK);
            if (DECODER_ENABLED) first = c;
        end
        checks++;
        if (first !== 2) begin
            failures++;
            $display("FAIL straight_latency first_issue_cycle=%0d required=2", first);
        end
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge CLK);
        #1; STALL = 1'b1; mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL straight_drain left=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        apply_reset();
        push_range(32'h0, 16);
        for (int i = 0; i < 100 && n_issued < 3; i++) begin
            @(posedge CLK);
            #1;
        end
        STALL = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++;
            if (DECODER_ENABLED !== 1'b0) begin
                failures++;
                $display("FAIL stall_no_issue cycle=%0d de=%b required=0", i, DECODER_ENABLED);
            end
        end
        checks++;
        if (IMEM_REQ !== 1'b0 || (n_granted - n_issued) != 2) begin
            failures++;
            $display("FAIL stall_limit req=%b in_flight=%0d required 0 2", IMEM_REQ, n_granted - n_issued);
        end
        @(posedge CLK);
        #1; STALL = 1'b0; gnt_rand = 1'b1;
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge CLK);
        #1; STALL = 1'b1; mon_en = 1'b0; gnt_rand = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL stall_drain left=%0d required=0", exp_q.size());
        end
    endtask

    task automatic test_branch();
        br_addr = 32'h10;
        apply_reset();
        push_range(32'h0, 5);
        push_range(32'h40, 4);
        for (int i = 0; i < 100 && n_issued < 5; i++) begin
            @(posedge CLK);
            #1;
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            checks++;
            if (IMEM_REQ !== 1'b0 || DECODER_ENABLED !== 1'b0) begin
                failures++;
                $display("FAIL branch_wait cycle=%0d req=%b de=%b required 0 0", i, IMEM_REQ, DECODER_ENABLED);
            end
            @(posedge CLK);
            #1;
        end
        REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h40;
        @(posedge CLK);
        #1; REDIRECT_VALID = 1'b0;
        @(negedge CLK);
        checks++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h40) begin
            failures++;
            $display("FAIL branch_resume req=%b addr=%h required 1 00000040", IMEM_REQ, IMEM_ADDR);
        end
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge CLK);
        #1; STALL = 1'b1; mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL branch_drain left=%0d required=0", exp_q.size());
        end
        br_addr = NO_ADDR;
    endtask

    task automatic test_mret();
        mret_addr = 32'h8;
        apply_reset();
        push_range(32'h0, 3);
        push_range(32'h80, 4);
        for (int i = 0; i < 100 && n_issued < 3; i++) begin
            @(posedge CLK);
            #1;
        end
        // Redirect straight away while a wrong-path response is still in flight.
        REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h80;
        @(negedge CLK);
        checks++;
        if (IMEM_REQ !== 1'b0 || DECODER_ENABLED !== 1'b0) begin
            failures++;
            $display("FAIL mret_redirect_cycle req=%b de=%b required 0 0", IMEM_REQ, DECODER_ENABLED);
        end
        @(posedge CLK);
        #1; REDIRECT_VALID = 1'b0;
        @(negedge CLK);
        checks++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h80) begin
            failures++;
            $display("FAIL mret_resume req=%b addr=%h required 1 00000080", IMEM_REQ, IMEM_ADDR);
        end
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge CLK);
        #1; STALL = 1'b1; mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL mret_drain left=%0d required=0", exp_q.size());
        end
        mret_addr = NO_ADDR;
    endtask

    task automatic test_redirect_same_cycle();
        logic found;
        jal_addr = 32'h8;
        apply_reset();
        push_range(32'h0, 2);
        push_range(32'h100, 4);
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (INSTRUCTION === JAL_WORD && PC === 32'h8) begin
                found = 1'b1;
                break;
            end
            @(posedge CLK);
            #1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL jal_head_seen found=0 required=1");
        end
        REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h103;
        @(negedge CLK);
        checks++;
        if (DECODER_ENABLED !== 1'b0) begin
            failures++;
            $display("FAIL redirect_blocks_issue de=%b required=0", DECODER_ENABLED);
        end
        @(posedge CLK);
        #1; REDIRECT_VALID = 1'b0;
        @(negedge CLK);
        checks++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h100) begin
            failures++;
            $display("FAIL redirect_align req=%b addr=%h required 1 00000100", IMEM_REQ, IMEM_ADDR);
        end
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge CLK);
        #1; STALL = 1'b1; mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL redirect_drain left=%0d required=0", exp_q.size());
        end
        jal_addr = NO_ADDR;
    endtask

    task automatic test_reset_mid();
        logic found;
        mem_delay = 3;
        apply_reset();
        mon_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (DECODER_ENABLED === 1'b1 && PC === 32'h4) begin
                found = 1'b1;
                break;
            end
            @(posedge CLK);
            #1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL reset_mid_setup found=0 required=1");
        end
        #2; RST = 1'b1;
        #1;
        checks++;
        if (IMEM_REQ !== 1'b0 || DECODER_ENABLED !== 1'b0 || INSTRUCTION !== NOP_TB || PC !== RESET_PC_TB) begin
            failures++;
            $display("FAIL reset_async req=%b de=%b insn=%h pc=%h required 0 0 %h %h",
                     IMEM_REQ, DECODER_ENABLED, INSTRUCTION, PC, NOP_TB, RESET_PC_TB);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0; n_issued = 0; n_granted = 0;
        exp_q.delete();
        push_range(RESET_PC_TB, 8);
        mon_en = 1'b1;
        @(negedge CLK);
        checks++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== RESET_PC_TB) begin
            failures++;
            $display("FAIL reset_restart req=%b addr=%h required 1 %h", IMEM_REQ, IMEM_ADDR, RESET_PC_TB);
        end
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge CLK);
        #1; STALL = 1'b1; mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_drain left=%0d required=0", exp_q.size());
        end
        mem_delay = 1;
    endtask

    initial begin
        checks = 0; failures = 0; n_issued = 0; n_granted = 0; cyc = 0;
        RST = 1'b1; STALL = 1'b0; REDIRECT_VALID = 1'b0; REDIRECT_PC = 32'h0;
        IMEM_GNT = 1'b1; IMEM_RVALID = 1'b0; IMEM_RDATA = 32'h0;
        mon_en = 1'b0; mem_delay = 1; gnt_rand = 1'b0; acc = 1'b0; acc_addr = 32'h0;
        br_addr = NO_ADDR; jal_addr = NO_ADDR; mret_addr = NO_ADDR;
        test_reset();
        test_straight();
        test_stall();
        test_branch();
        test_mret();
        test_redirect_same_cycle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
